flash_read_responder: RTL and testbench
=======================================

Name: flash_read_responder

Overview:
- Read-only memory-mapped responder that serves the 32-bit word reads issued by the jukebox playback FSM (flash_mem_read / flash_mem_address / flash_mem_readdata) from the board's 8-bit parallel flash chip.
- Each accepted word read becomes four timed byte accesses on the chip pins. The bytes are assembled little-endian and returned with a one-cycle valid pulse.
- Sits between the playback FSM and the top-level flash pins.

Parameters:
- ADDR_W, 23, word address width on the request side; chip byte address width is ADDR_W+2.
- WAIT_CYCLES, 4, clk cycles each byte address is held before fl_dq_in is sampled; legal range is 1..15 (0 is illegal).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- flash_mem_read  input  1  read request; accepted on a cycle where flash_mem_read=1 and flash_mem_waitrequest=0.
- flash_mem_address  input  ADDR_W  word address, sampled at acceptance.
- flash_mem_waitrequest  output  1  1 while the block cannot accept a request.
- flash_mem_readdata  output  32  assembled word; byte0 in [7:0].
- flash_mem_readdatavalid  output  1  one-cycle pulse; readdata is valid in that cycle.
- fl_addr  output  ADDR_W+2  chip byte address.
- fl_ce_n  output  1  chip enable, active low.
- fl_oe_n  output  1  output enable, active low.
- fl_we_n  output  1  tied to 1 (read-only block).
- fl_dq_in  input  8  chip data bus.

Behaviour:
- Reset values (cycle after reset=1):
  - state IDLE; flash_mem_waitrequest=0; flash_mem_readdatavalid=0; flash_mem_readdata=0.
  - fl_ce_n=1; fl_oe_n=1; fl_addr=0; fl_we_n=1.
  - Byte index, wait counter and latched address all 0.
- States: IDLE, ACCESS, RESP.
- flash_mem_waitrequest = 1 exactly when the state is not IDLE. This signal is decoded from the registered state with no input dependence.
- IDLE:
  - If flash_mem_read=1, the request is accepted. Latch flash_mem_address, clear byte index and counter, go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - Drive fl_ce_n=0, fl_oe_n=0, fl_addr = {latched address, byte index}.
  - The counter counts 0..WAIT_CYCLES-1.
  - On the cycle counter = WAIT_CYCLES-1, capture fl_dq_in into byte lane [8*idx+7 : 8*idx], clear the counter, and increment idx.
  - After the lane-3 capture, go to RESP.
- RESP:
  - flash_mem_readdatavalid=1 for exactly this cycle.
  - fl_ce_n=1, fl_oe_n=1.
  - Next state is IDLE.
- Latency: with acceptance in cycle T, ACCESS occupies cycles T+1..T+4*WAIT_CYCLES and readdatavalid is high in cycle T+4*WAIT_CYCLES+1. The earliest next acceptance is cycle T+4*WAIT_CYCLES+2. With WAIT_CYCLES=4: valid at T+17, next accept at T+18.
- flash_mem_readdata holds its last assembled value between responses. The lanes update only at capture, so intermediate cycles show partially new data; consumers use it only when readdatavalid=1.
- Requests while busy are not accepted and not queued. Address changes after acceptance are ignored. Each acceptance yields exactly one readdatavalid pulse.
- Address range: the full range is legal with no wrap. Word 2^ADDR_W-1 maps to byte addresses {all ones, 00..11}.
- Reset mid-operation: the transaction is aborted. The cycle after reset, fl_ce_n=fl_oe_n=1 and waitrequest=0, and no readdatavalid is ever issued for the aborted request.

Optional Feature:
- FLASH_LAST_WORD_CACHE_EN defined:
  - Keep a one-entry tag (last completed word address plus valid bit, cleared by reset and by an aborted transaction).
  - An IDLE acceptance whose address matches a valid tag skips ACCESS and goes directly to RESP with the stored word: readdatavalid in T+1, with no fl_ce_n/fl_oe_n activity.
  - A miss behaves as normal and updates the tag on completion.
  - Purpose: the playback FSM reads each word twice, once per 16-bit sample.
- Undefined: no tag logic; every read takes the full latency.

Test Plan:
All scenarios use WAIT_CYCLES=4, and the flash model returns data = fl_addr[7:0].
- Reset held for 2 cycles, then idle → waitrequest=0, fl_ce_n=1, fl_oe_n=1, readdatavalid=0, readdata=0.
- Read of word 0x000010 accepted at T → fl_addr = 0x40, 0x41, 0x42, 0x43, each held 4 cycles with ce_n/oe_n low; readdatavalid only at T+17 with readdata=32'h43424140; waitrequest=0 at T+18.
- flash_mem_read held high continuously with the address switched to 0x000020 at T+3 → only one acceptance until T+18; second response = 32'h83828180; exactly 2 valid pulses total.
- reset asserted at T+7 of a read → ce_n/oe_n high and waitrequest=0 the next cycle; no readdatavalid for the next 20 cycles; a subsequent read of word 0 returns 32'h03020100.
- Read of word 0x7FFFFF → fl_addr runs 0x1FFFFFC..0x1FFFFFF; readdata=32'hFFFEFDFC.
- With FLASH_LAST_WORD_CACHE_EN, read 0x10 twice: the second acceptance gets readdatavalid at T+1 with 32'h43424140 and fl_ce_n stays 1. Without the macro, the second read completes at T+17.

Source files
------------

// File: rtl/flash_mem_if.sv
// Word-read bus between the playback FSM (master) and flash_read_responder (slave).
interface flash_mem_if #(
    parameter int ADDR_W = 23
) ();
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic              flash_mem_waitrequest;
    logic [31:0]       flash_mem_readdata;
    logic              flash_mem_readdatavalid;

    modport master (
        output flash_mem_read,
        output flash_mem_address,
        input  flash_mem_waitrequest,
        input  flash_mem_readdata,
        input  flash_mem_readdatavalid
    );

    modport slave (
        input  flash_mem_read,
        input  flash_mem_address,
        output flash_mem_waitrequest,
        output flash_mem_readdata,
        output flash_mem_readdatavalid
    );
endinterface

// File: rtl/flash_read_responder.sv
// Serves 32-bit word reads from an 8-bit parallel flash as four timed byte reads, assembled little-endian.
// Define FLASH_LAST_WORD_CACHE_EN to answer a repeat read of the last completed word without touching the chip.
module flash_read_responder #(
    parameter int ADDR_W      = 23,
    parameter int WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    flash_mem_if.slave        bus,
    output logic [ADDR_W+1:0] fl_addr,
    output logic              fl_ce_n,
    output logic              fl_oe_n,
    output logic              fl_we_n,
    input  logic [7:0]        fl_dq_in
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        idx;
    logic [3:0]        cnt;
    logic [31:0]       readdata_q;
    logic              accept;
    logic              byte_done;
    logic              word_done;
    logic              hit;

    assign accept    = (state == IDLE) && bus.flash_mem_read;
    assign byte_done = (state == ACCESS) && (cnt == CNT_LAST);
    assign word_done = byte_done && (idx == 2'd3);

`ifdef FLASH_LAST_WORD_CACHE_EN
    logic [ADDR_W-1:0] tag_q;
    logic              tag_valid;

    // readdata_q always equals the tagged word: only completions write all lanes, and reset clears both.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q     <= '0;
            tag_valid <= 1'b0;
        end else if (word_done) begin
            tag_q     <= addr_q;
            tag_valid <= 1'b1;
        end
    end

    assign hit = tag_valid && (bus.flash_mem_address == tag_q);
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next                  = state;
        fl_ce_n                     = 1'b1;
        fl_oe_n                     = 1'b1;
        bus.flash_mem_waitrequest   = (state != IDLE);
        bus.flash_mem_readdatavalid = (state == RESP);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = hit ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                fl_ce_n = 1'b0;
                fl_oe_n = 1'b0;
                if (word_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte sequencer: each byte address is held WAIT_CYCLES cycles, the chip data is sampled on the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            idx        <= 2'd0;
            cnt        <= 4'd0;
            readdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= bus.flash_mem_address;
                        idx    <= 2'd0;
                        cnt    <= 4'd0;
                    end
                end
                ACCESS: begin
                    if (cnt == CNT_LAST) begin
                        readdata_q[{idx, 3'b000} +: 8] <= fl_dq_in;
                        cnt                            <= 4'd0;
                        idx                            <= idx + 2'd1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign fl_addr                = {addr_q, idx};
    assign fl_we_n                = 1'b1;
    assign bus.flash_mem_readdata = readdata_q;
endmodule

// File: tb/tb_flash_read_responder.sv
// Self-checking bench for flash_read_responder; the flash model returns fl_addr[7:0] as data.
module tb_flash_read_responder;
    localparam int ADDR_W      = 23;
    localparam int BW          = ADDR_W + 2;
    localparam int WAIT_CYCLES = 4;
    localparam int FULL_LAT    = 4 * WAIT_CYCLES + 1;
`ifdef FLASH_LAST_WORD_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] fl_addr;
    logic          fl_ce_n;
    logic          fl_oe_n;
    logic          fl_we_n;
    logic [7:0]    fl_dq_in;

    flash_mem_if #(.ADDR_W(ADDR_W)) bus ();

    flash_read_responder #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .fl_addr  (fl_addr),
        .fl_ce_n  (fl_ce_n),
        .fl_oe_n  (fl_oe_n),
        .fl_we_n  (fl_we_n),
        .fl_dq_in (fl_dq_in)
    );

    always #5 clk = ~clk;

    assign fl_dq_in = fl_addr[7:0];

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: last completed word address, forgotten on reset.
    bit                model_tag_valid = 1'b0;
    logic [ADDR_W-1:0] model_tag       = '0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       word;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [31:0] model_word(input logic [ADDR_W-1:0] a);
        logic [BW-1:0] base;
        logic [BW-1:0] ba;
        logic [31:0]   w;
        base = {a, 2'b00};
        w    = '0;
        for (int i = 0; i < 4; i++) begin
            ba           = base + BW'(i);
            w[i*8 +: 8]  = ba[7:0];
        end
        return w;
    endfunction

    function automatic int model_latency(input logic [ADDR_W-1:0] a);
        if (CACHE_EN && model_tag_valid && (model_tag == a)) begin
            return 1;
        end
        return FULL_LAT;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one read from an idle negedge and checks data, latency, pin trace and the return to idle.
    task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [31:0] exp_word, input string tag);
        int            lat;
        int            exp_lat;
        logic [31:0]   data;
        bit            pins_ok;
        logic [BW-1:0] exp_fa;
        lat     = -1;
        data    = '0;
        pins_ok = 1'b1;
        exp_lat = model_latency(a);
        bus.flash_mem_read    = 1'b1;
        bus.flash_mem_address = a;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            bus.flash_mem_read    = 1'b0;
            bus.flash_mem_address = ADDR_W'($urandom);
            if (bus.flash_mem_readdatavalid === 1'b1) begin
                lat  = n;
                data = bus.flash_mem_readdata;
                if (fl_ce_n !== 1'b1 || fl_oe_n !== 1'b1) pins_ok = 1'b0;
                break;
            end
            exp_fa = {a, 2'b00};
            exp_fa = exp_fa + BW'((n - 1) / WAIT_CYCLES);
            if (fl_ce_n !== 1'b0 || fl_oe_n !== 1'b0 || fl_addr !== exp_fa ||
                bus.flash_mem_waitrequest !== 1'b1 || fl_we_n !== 1'b1) begin
                pins_ok = 1'b0;
            end
        end
        checkOutput($sformatf("%s_data", tag), data, exp_word);
        checkOutput($sformatf("%s_latency", tag), 32'(lat), 32'(exp_lat));
        checkOutput($sformatf("%s_pins", tag), {31'd0, pins_ok}, 32'd1);
        @(negedge clk);
        checkOutput($sformatf("%s_idle_after", tag),
                    {30'd0, bus.flash_mem_readdatavalid, bus.flash_mem_waitrequest}, 32'd0);
        model_tag       = a;
        model_tag_valid = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            valids;
        int            n1;
        int            n2;
        logic [31:0]   d1;
        logic [31:0]   d2;
        logic          wr18;
        logic [ADDR_W-1:0] prev;

        vecs[0] = '{23'h000010, 32'h43424140};
        vecs[1] = '{23'h000010, 32'h43424140};
        vecs[2] = '{23'h000020, 32'h83828180};
        vecs[3] = '{23'h000000, 32'h03020100};
        vecs[4] = '{23'h7FFFFF, 32'hFFFEFDFC};
        vecs[5] = '{23'h000001, 32'h07060504};
        vecs[6] = '{23'h123456, 32'h5B5A5958};

        reset                 = 1'b1;
        bus.flash_mem_read    = 1'b0;
        bus.flash_mem_address = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_waitrequest", {31'd0, bus.flash_mem_waitrequest}, 32'd0);
        checkOutput("reset_ce_oe_we", {29'd0, fl_ce_n, fl_oe_n, fl_we_n}, 32'd7);
        checkOutput("reset_valid", {31'd0, bus.flash_mem_readdatavalid}, 32'd0);
        checkOutput("reset_readdata", bus.flash_mem_readdata, 32'd0);
        checkOutput("reset_fl_addr", 32'(fl_addr), 32'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].word, $sformatf("vec%0d", i));
        end

        // Read held high throughout, address switched mid-transaction: two accepts, two pulses.
        valids = 0; n1 = -1; n2 = -1; d1 = '0; d2 = '0; wr18 = 1'b1;
        bus.flash_mem_read    = 1'b1;
        bus.flash_mem_address = 23'h000010;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 3) bus.flash_mem_address = 23'h000020;
            if (n == 18) wr18 = bus.flash_mem_waitrequest;
            if (bus.flash_mem_readdatavalid === 1'b1) begin
                valids++;
                if (valids == 1) begin
                    n1 = n;
                    d1 = bus.flash_mem_readdata;
                end else begin
                    n2 = n;
                    d2 = bus.flash_mem_readdata;
                    bus.flash_mem_read = 1'b0;
                    break;
                end
            end
        end
        bus.flash_mem_read = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.flash_mem_readdatavalid === 1'b1) valids++;
        end
        checkOutput("hold_first_data", d1, 32'h43424140);
        checkOutput("hold_first_latency", 32'(n1), 32'(FULL_LAT));
        checkOutput("hold_waitrequest_release", {31'd0, wr18}, 32'd0);
        checkOutput("hold_second_data", d2, 32'h83828180);
        checkOutput("hold_second_latency", 32'(n2), 32'(2 * FULL_LAT + 1));
        checkOutput("hold_pulse_count", 32'(valids), 32'd2);
        model_tag       = 23'h000020;
        model_tag_valid = 1'b1;

        // Reset in the middle of an access aborts it with no response.
        bus.flash_mem_read    = 1'b1;
        bus.flash_mem_address = 23'h000010;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            bus.flash_mem_read = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_tag_valid = 1'b0;
        checkOutput("abort_ce_oe", {30'd0, fl_ce_n, fl_oe_n}, 32'd3);
        checkOutput("abort_waitrequest", {31'd0, bus.flash_mem_waitrequest}, 32'd0);
        checkOutput("abort_readdata", bus.flash_mem_readdata, 32'd0);
        valids = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.flash_mem_readdatavalid === 1'b1) valids++;
        end
        checkOutput("abort_no_valid", 32'(valids), 32'd0);
        applyStimulus(23'h000000, 32'h03020100, "after_abort");

        // Random addresses, often repeating the previous one to exercise the tag path.
        prev = 23'h000000;
        for (int i = 0; i < 24; i++) begin
            logic [ADDR_W-1:0] a;
            a = ($urandom_range(0, 1) == 1) ? prev : ADDR_W'($urandom);
            applyStimulus(a, model_word(a), $sformatf("rand%0d", i));
            prev = a;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
